id_branch_ctrl: RTL and testbench
=================================

# id_branch_ctrl

Decode-stage branch resolution controller. Selects and forwards the two branch operands into the ID-stage 32-bit equality comparator, detects operand hazards against the EX and MEM stages, and stalls ID until the operands are valid. It then evaluates the branch condition and issues a registered, single-cycle PC redirect to IF. It sits between the ID pipeline register, the register file read ports, the forwarding buses and the IF PC-select logic.

## Interface
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

- `clk` in 1: pipeline clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline flush (exception/eret); aborts any pending branch.
- `br_valid` in 1: ID holds a conditional branch; held stable by upstream while `stall_id`=1.
- `br_op` in 2: 00 BEQ, 01 BNE, 10 BGEZ, 11 BLTZ.
- `rs_addr`, `rt_addr` in 5: source register numbers.
- `rs_rdata`, `rt_rdata` in 32: register file read data (WB write-through already applied).
- `br_target` in 32: precomputed branch target.
- `ex_wreg` in 1, `ex_waddr` in 5: EX-stage instruction writes a register.
- `mem_wreg` in 1, `mem_waddr` in 5, `mem_is_load` in 1, `mem_wdata` in 32: MEM-stage writeback info; `mem_wdata` valid only when `mem_is_load`=0.
- `cmp_a`, `cmp_b` out 32: operands driven to the external equality comparator.
- `cmp_eq` in 1: comparator result (combinational from `cmp_a`/`cmp_b`).
- `stall_id` out 1: hold IF/ID this cycle.
- `redirect_valid` out 1: registered; load `redirect_pc` into the PC.
- `redirect_pc` out 32: registered target.
- `cnt_clr` in 1: synchronous clear of `stall_cnt`.
- `stall_cnt` out CNT_W: saturating count of stall cycles.

## Operation
- Operand use: rs is used by all ops; rt is used only by BEQ/BNE. A register numbered 0 never creates a hazard and always reads as 0.
- Hazard (per used operand r≠0): (`ex_wreg` & `ex_waddr`==r), or (`mem_wreg` & `mem_is_load` & `mem_waddr`==r).
- Forwarding: if `mem_wreg` & !`mem_is_load` & `mem_waddr`==r, the operand is `mem_wdata`; otherwise it is the register file data.
- `cmp_a` is forwarded rs. `cmp_b` is forwarded rt for BEQ/BNE and 0 otherwise. Both are driven every cycle.
- Taken: BEQ `cmp_eq`; BNE !`cmp_eq`; BGEZ !rs[31]; BLTZ rs[31] (rs after forwarding).
- FSM states:
  - IDLE: no branch pending. On `br_valid` & hazard → WAIT. On `br_valid` & !hazard → resolve.
  - WAIT: stalled. Re-evaluate each cycle. On hazard cleared → resolve.
  - REDIR: one cycle. `redirect_valid`=1. `br_valid` is ignored, since the delay-slot instruction is never a branch. Always → IDLE.
  - Resolve: if taken, go to REDIR and latch `redirect_pc` ← `br_target`. If not taken, go to IDLE.
- `stall_id` = `br_valid` & hazard & !`flush` & state≠REDIR. It is combinational.
- `flush` has priority over everything. The next state is IDLE, no redirect is issued, and `stall_id`=0. A `redirect_valid` already asserted in this same cycle is not retracted.
- Counter: increments when `stall_id`=1 and saturates at all-ones. `cnt_clr` has priority over the increment.
- Reset values: state IDLE, `redirect_valid`=0, `redirect_pc`=0, `stall_cnt`=0. `stall_id` is 0 during reset.

## Timing
- No hazard: branch in ID at cycle T, resolved in T. `redirect_valid`=1 in T+1 for exactly one cycle. `stall_id`=0 throughout.
- EX hazard on an ALU op: `stall_id`=1 in T. In T+1 the producer is in MEM and is forwarded. The branch resolves in T+1 and redirects in T+2.
- EX hazard on a load: stall in T and T+1 (the load is in MEM in T+1), then resolve in T+2 via the register file write-through.
- The comparator path is combinational within the resolve cycle. Only the decision is registered.
- Simultaneous hazard on rs and rt: stall until both clear.

## Test plan
- BEQ, rs=5 (0x1234), rt=6 (0x1234), no hazards → `stall_id` stays 0. Next cycle `redirect_valid`=1 and `redirect_pc`=`br_target`. Then state IDLE.
- BNE, rs=7, with EX writing r7 (ALU op) → 1 stall cycle. Next cycle `mem_wdata`=0x5 forwarded to `cmp_a`. rt=0x5 → not taken, no redirect. `stall_cnt`=1.
- BGEZ, rs=8, with EX load writing r8 → 2 stall cycles. Register file returns 0x8000_0000 → not taken. BLTZ in the same scenario → taken.
- BEQ rs=0, rt=0, with `ex_waddr`=0 and `ex_wreg`=1 → no stall, taken.
- BEQ in WAIT, `flush`=1 → next cycle IDLE, `redirect_valid` never rises. Assert `rst` mid-WAIT → all outputs at reset values next cycle.
- Force stall_cnt to all-ones minus 1, then stall 3 cycles → saturates at all-ones. `cnt_clr` together with a stall → 0.

Source files
------------

// File: rtl/id_branch_ctrl.sv
// Decode-stage branch resolution: operand forwarding into the external equality
// comparator, EX/MEM hazard stall, and a registered single-cycle PC redirect.
module id_branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [1:0]       br_op,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    input  logic [31:0]      rs_rdata,
    input  logic [31:0]      rt_rdata,
    input  logic [31:0]      br_target,
    input  logic             ex_wreg,
    input  logic [4:0]       ex_waddr,
    input  logic             mem_wreg,
    input  logic [4:0]       mem_waddr,
    input  logic             mem_is_load,
    input  logic [31:0]      mem_wdata,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic             cmp_eq,
    output logic             stall_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        rs_haz, rt_haz, rs_fwd, rt_fwd, rt_used, hazard, taken;
    logic [31:0] rs_val, rt_val;

    // r0 never hazards and never forwards; it is hard-wired to zero below.
    assign rs_haz = (rs_addr != 5'd0) &&
                    ((ex_wreg && (ex_waddr == rs_addr)) ||
                     (mem_wreg && mem_is_load && (mem_waddr == rs_addr)));
    assign rt_haz = (rt_addr != 5'd0) &&
                    ((ex_wreg && (ex_waddr == rt_addr)) ||
                     (mem_wreg && mem_is_load && (mem_waddr == rt_addr)));
    assign rs_fwd = (rs_addr != 5'd0) && mem_wreg && !mem_is_load && (mem_waddr == rs_addr);
    assign rt_fwd = (rt_addr != 5'd0) && mem_wreg && !mem_is_load && (mem_waddr == rt_addr);

    assign rs_val = (rs_addr == 5'd0) ? 32'd0 : (rs_fwd ? mem_wdata : rs_rdata);
    assign rt_val = (rt_addr == 5'd0) ? 32'd0 : (rt_fwd ? mem_wdata : rt_rdata);

    // BGEZ/BLTZ compare rs alone, so rt neither stalls nor reaches the comparator.
    assign rt_used = !br_op[1];
    assign hazard  = rs_haz || (rt_used && rt_haz);
    assign cmp_a   = rs_val;
    assign cmp_b   = rt_used ? rt_val : 32'd0;

    always_comb begin
        taken = 1'b0;
        case (br_op)
            2'b00:   taken = cmp_eq;
            2'b01:   taken = !cmp_eq;
            2'b10:   taken = !rs_val[31];
            default: taken = rs_val[31];
        endcase
    end

    assign stall_id = br_valid && hazard && !flush && (state_q != ST_REDIR) && !rst;

    always_comb begin
        state_d          = ST_IDLE;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (flush || (state_q == ST_REDIR)) begin
            state_d = ST_IDLE;
        end else if (br_valid) begin
            if (hazard) begin
                state_d = ST_WAIT;
            end else if (taken) begin
                state_d          = ST_REDIR;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = br_target;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall_id && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            stall_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall_cnt      = stall_cnt_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Bench for id_branch_ctrl: directed scenarios plus randomized traffic checked
// against an array-based reference model and an expected-redirect queue.
module tb_id_branch_ctrl;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;
    localparam logic [1:0] BEQ = 2'b00, BNE = 2'b01, BGEZ = 2'b10, BLTZ = 2'b11;

    logic             clk = 1'b0;
    logic             rst, flush, br_valid, cnt_clr;
    logic [1:0]       br_op;
    logic [4:0]       rs_addr, rt_addr, ex_waddr, mem_waddr;
    logic [31:0]      rs_rdata, rt_rdata, br_target, mem_wdata;
    logic             ex_wreg, mem_wreg, mem_is_load;
    logic [31:0]      cmp_a, cmp_b;
    logic             cmp_eq, stall_id, redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       dbg_state;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    id_branch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .br_valid(br_valid), .br_op(br_op),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_rdata(rs_rdata), .rt_rdata(rt_rdata),
        .br_target(br_target), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
        .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_is_load(mem_is_load),
        .mem_wdata(mem_wdata), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq),
        .stall_id(stall_id), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // External comparator
    assign cmp_eq = (cmp_a == cmp_b);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        flush = 0; br_valid = 0; cnt_clr = 0; br_op = BEQ;
        rs_addr = 0; rt_addr = 0; rs_rdata = 0; rt_rdata = 0; br_target = 0;
        ex_wreg = 0; ex_waddr = 0; mem_wreg = 0; mem_waddr = 0; mem_is_load = 0; mem_wdata = 0;
    endtask

    task automatic set_br(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] tgt);
        br_valid = 1; br_op = op; rs_addr = rs; rt_addr = rt;
        rs_rdata = rsd; rt_rdata = rtd; br_target = tgt;
    endtask

    task automatic clear_cnt();
        quiet(); cnt_clr = 1; tick(); cnt_clr = 0;
    endtask

    task automatic test_reset();
        quiet(); rst = 1;
        set_br(BEQ, 5'd3, 5'd4, 32'h1, 32'h1, 32'h40);
        ex_wreg = 1; ex_waddr = 5'd3;
        #1;
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_id); end
        tick(); tick();
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b want=0", redirect_valid); end
        checks++; if (redirect_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h want=0", redirect_pc); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
        checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, S_IDLE); end
        rst = 0; quiet(); tick();
    endtask

    task automatic test_no_hazard();
        quiet(); set_br(BEQ, 5'd5, 5'd6, 32'h1234, 32'h1234, 32'h0000_2000);
        #1;
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL nohaz_stall got=%b want=0", stall_id); end
        checks++; if (cmp_a !== 32'h1234 || cmp_b !== 32'h1234) begin failures++; $display("FAIL nohaz_cmp got=%h/%h want=1234/1234", cmp_a, cmp_b); end
        tick(); quiet();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000) begin failures++; $display("FAIL nohaz_redir got=%b/%h want=1/2000", redirect_valid, redirect_pc); end
        tick();
        checks++; if (redirect_valid !== 1'b0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL nohaz_after got=%b/%0d want=0/%0d", redirect_valid, dbg_state, S_IDLE); end
    endtask

    task automatic test_ex_alu();
        clear_cnt();
        set_br(BNE, 5'd7, 5'd9, 32'h99, 32'h5, 32'h3000);
        ex_wreg = 1; ex_waddr = 5'd7;
        #1;
        checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL alu_stall got=%b want=1", stall_id); end
        tick();
        checks++; if (dbg_state !== S_WAIT) begin failures++; $display("FAIL alu_wait got=%0d want=%0d", dbg_state, S_WAIT); end
        ex_wreg = 0; mem_wreg = 1; mem_waddr = 5'd7; mem_is_load = 0; mem_wdata = 32'h5;
        #1;
        checks++; if (stall_id !== 1'b0 || cmp_a !== 32'h5) begin failures++; $display("FAIL alu_fwd got=%b/%h want=0/5", stall_id, cmp_a); end
        tick(); quiet();
        checks++; if (redirect_valid !== 1'b0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL alu_notaken got=%b/%0d want=0/%0d", redirect_valid, dbg_state, S_IDLE); end
        checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL alu_cnt got=%0d want=1", stall_cnt); end
    endtask

    task automatic test_ex_load(input logic [1:0] op);
        clear_cnt();
        set_br(op, 5'd8, 5'd1, 32'h0, 32'h0, 32'h4000);
        ex_wreg = 1; ex_waddr = 5'd8;
        #1;
        checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL load_stall0 op=%0d got=%b want=1", op, stall_id); end
        tick();
        ex_wreg = 0; mem_wreg = 1; mem_waddr = 5'd8; mem_is_load = 1; mem_wdata = 32'h1;
        #1;
        checks++; if (stall_id !== 1'b1 || cmp_b !== 32'd0) begin failures++; $display("FAIL load_stall1 op=%0d got=%b/%h want=1/0", op, stall_id, cmp_b); end
        tick();
        mem_wreg = 0; mem_is_load = 0; rs_rdata = 32'h8000_0000;
        #1;
        checks++; if (stall_id !== 1'b0 || cmp_a !== 32'h8000_0000) begin failures++; $display("FAIL load_resolve op=%0d got=%b/%h want=0/80000000", op, stall_id, cmp_a); end
        tick(); quiet();
        checks++; if (redirect_valid !== (op == BLTZ)) begin failures++; $display("FAIL load_taken op=%0d got=%b want=%b", op, redirect_valid, op == BLTZ); end
        checks++; if (stall_cnt !== 4'd2) begin failures++; $display("FAIL load_cnt op=%0d got=%0d want=2", op, stall_cnt); end
        tick();
    endtask

    task automatic test_zero_reg();
        quiet(); set_br(BEQ, 5'd0, 5'd0, 32'hdead, 32'hbeef, 32'h5000);
        ex_wreg = 1; ex_waddr = 5'd0; mem_wreg = 1; mem_waddr = 5'd0; mem_wdata = 32'h77;
        #1;
        checks++; if (stall_id !== 1'b0 || cmp_a !== 32'd0 || cmp_b !== 32'd0) begin failures++; $display("FAIL zero_reg got=%b/%h/%h want=0/0/0", stall_id, cmp_a, cmp_b); end
        tick(); quiet();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h5000) begin failures++; $display("FAIL zero_taken got=%b/%h want=1/5000", redirect_valid, redirect_pc); end
        tick();
    endtask

    task automatic test_flush();
        quiet(); set_br(BEQ, 5'd2, 5'd2, 32'h1, 32'h1, 32'h6000);
        ex_wreg = 1; ex_waddr = 5'd2;
        tick();
        flush = 1;
        #1;
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b want=0", stall_id); end
        tick(); flush = 0; ex_wreg = 0; br_valid = 0;
        checks++; if (dbg_state !== S_IDLE || redirect_valid !== 1'b0) begin failures++; $display("FAIL flush_idle got=%0d/%b want=%0d/0", dbg_state, redirect_valid, S_IDLE); end
        tick();
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL flush_norv got=%b want=0", redirect_valid); end
        // flush during the redirect cycle does not retract it
        quiet(); set_br(BEQ, 5'd3, 5'd4, 32'h9, 32'h9, 32'h6100);
        tick(); quiet(); flush = 1;
        #1;
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL flush_redir got=%b want=1", redirect_valid); end
        tick(); flush = 0;
        checks++; if (redirect_valid !== 1'b0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL flush_after got=%b/%0d want=0/%0d", redirect_valid, dbg_state, S_IDLE); end
        // reset asserted mid-WAIT
        set_br(BNE, 5'd4, 5'd5, 32'h1, 32'h2, 32'h6200);
        ex_wreg = 1; ex_waddr = 5'd5;
        tick();
        rst = 1;
        #1;
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL rstwait_stall got=%b want=0", stall_id); end
        tick(); rst = 0; quiet();
        checks++; if (dbg_state !== S_IDLE || redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || stall_cnt !== '0) begin
            failures++; $display("FAIL rstwait_vals got=%0d/%b/%h/%0d want=0/0/0/0", dbg_state, redirect_valid, redirect_pc, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        clear_cnt();
        set_br(BEQ, 5'd10, 5'd11, 32'h0, 32'h0, 32'h7000);
        ex_wreg = 1; ex_waddr = 5'd10;
        for (int i = 0; i < int'(CNT_MAX) - 1; i++) tick();
        checks++; if (stall_cnt !== CNT_MAX - 4'd1) begin failures++; $display("FAIL sat_pre got=%0d want=%0d", stall_cnt, CNT_MAX - 4'd1); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (stall_cnt !== CNT_MAX) begin failures++; $display("FAIL sat_hold%0d got=%0d want=%0d", i, stall_cnt, CNT_MAX); end
        end
        cnt_clr = 1;
        #1;
        checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL sat_clr_stall got=%b want=1", stall_id); end
        tick(); cnt_clr = 0;
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL sat_clr got=%0d want=0", stall_cnt); end
        quiet(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        quiet(); set_br(BNE, 5'd12, 5'd13, 32'h1, 32'h2, 32'h8000);
        tick();
        set_br(BEQ, 5'd14, 5'd14, 32'h3, 32'h3, 32'h8800);
        ex_wreg = 1; ex_waddr = 5'd14;
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000 || stall_id !== 1'b0) begin
            failures++; $display("FAIL b2b_redir got=%b/%h/%b want=1/8000/0", redirect_valid, redirect_pc, stall_id);
        end
        tick(); quiet();
        checks++; if (redirect_valid !== 1'b0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL b2b_ignored got=%b/%0d want=0/%0d", redirect_valid, dbg_state, S_IDLE); end
        tick();
    endtask

    task automatic test_random();
        logic        busy[32];
        logic        byp[32];
        logic [31:0] a, b, regv, e_pc;
        logic        haz, tk, e_stall, in_redir, e_redir, e_wait, hold;
        logic [CNT_W-1:0] m_cnt;
        logic [1:0]  e_state;
        quiet(); rst = 1; tick(); rst = 0;
        in_redir = 0; hold = 0; m_cnt = '0; e_pc = 32'd0;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                br_valid = ($urandom_range(0, 2) != 0);
                br_op = 2'($urandom_range(0, 3));
                rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
                br_target = $urandom;
            end
            // small value space so BEQ/BNE see both outcomes
            rs_rdata = ($urandom_range(0, 1) != 0) ? 32'h8000_0001 : 32'h1;
            rt_rdata = ($urandom_range(0, 1) != 0) ? 32'h8000_0001 : 32'h1;
            ex_wreg = ($urandom_range(0, 2) == 0); ex_waddr = 5'($urandom_range(0, 3));
            mem_wreg = ($urandom_range(0, 1) != 0); mem_waddr = 5'($urandom_range(0, 3));
            mem_is_load = ($urandom_range(0, 1) != 0);
            mem_wdata = ($urandom_range(0, 1) != 0) ? 32'h8000_0001 : 32'h1;
            flush = ($urandom_range(0, 15) == 0);
            cnt_clr = ($urandom_range(0, 15) == 0);
            for (int r = 0; r < 32; r++) begin
                busy[r] = (r != 0) && ((ex_wreg && ex_waddr == 5'(r)) || (mem_wreg && mem_is_load && mem_waddr == 5'(r)));
                byp[r]  = (r != 0) && mem_wreg && !mem_is_load && mem_waddr == 5'(r);
            end
            a = (rs_addr == 0) ? 32'd0 : (byp[rs_addr] ? mem_wdata : rs_rdata);
            regv = (rt_addr == 0) ? 32'd0 : (byp[rt_addr] ? mem_wdata : rt_rdata);
            b = (br_op < 2) ? regv : 32'd0;
            haz = busy[rs_addr] || (br_op < 2 && busy[rt_addr]);
            case (br_op)
                BEQ:     tk = (a == b);
                BNE:     tk = (a != b);
                BGEZ:    tk = (a[31] == 1'b0);
                default: tk = (a[31] == 1'b1);
            endcase
            e_stall = br_valid && haz && !flush && !in_redir;
            #1;
            checks++; if (stall_id !== e_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, stall_id, e_stall); end
            checks++; if (cmp_a !== a || cmp_b !== b) begin failures++; $display("FAIL rnd_cmp n=%0d got=%h/%h want=%h/%h", n, cmp_a, cmp_b, a, b); end
            e_redir = !flush && !in_redir && br_valid && !haz && tk;
            e_wait  = e_stall;
            if (e_redir) begin
                e_pc = br_target;
                exp_q.push_back(br_target);
            end
            if (cnt_clr) m_cnt = '0;
            else if (e_stall && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
            e_state = e_redir ? S_REDIR : (e_wait ? S_WAIT : S_IDLE);
            tick();
            checks++; if (redirect_valid !== e_redir) begin failures++; $display("FAIL rnd_rv n=%0d got=%b want=%b", n, redirect_valid, e_redir); end
            if (redirect_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_unexpected_redir n=%0d got=%h want=none", n, redirect_pc); end
                else begin
                    regv = exp_q.pop_front();
                    if (redirect_pc !== regv) begin failures++; $display("FAIL rnd_pc n=%0d got=%h want=%h", n, redirect_pc, regv); end
                end
            end
            checks++; if (redirect_pc !== e_pc) begin failures++; $display("FAIL rnd_pcreg n=%0d got=%h want=%h", n, redirect_pc, e_pc); end
            checks++; if (stall_cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, stall_cnt, m_cnt); end
            checks++; if (dbg_state !== e_state) begin failures++; $display("FAIL rnd_state n=%0d got=%0d want=%0d", n, dbg_state, e_state); end
            in_redir = e_redir;
            hold = e_stall;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_leftover got=%0d want=0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        rst = 1; quiet();
        tick(); tick();
        test_reset();
        test_no_hazard();
        test_ex_alu();
        test_ex_load(BGEZ);
        test_ex_load(BLTZ);
        test_zero_reg();
        test_flush();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
